mi_nios_mult_sequencer: RTL and testbench
=========================================

// Module: mi_nios_mult_sequencer
// PURPOSE
//  Drives the 16x16 three-partial-product multiply cell and assembles its outputs into 32-bit results.
//  Accepts one multiply request per handshake, runs one or two passes through the cell, and returns the
//  low or high 32 bits of the 64-bit product.
//  Sits between the execute-stage request path and the multiply cell.
//  Supported ops: MUL (low word), MULXUU, MULXSU, MULXSS (high word, signedness per operand).
// PARAMETERS
//  CELL_LATENCY  1   clocks from first cell_en edge with operands applied to valid cell_p*; legal range 1..4
// PORTS
//  clk           in   1   single clock, rising edge
//  reset_n       in   1   asynchronous, active-low reset
//  req_valid     in   1   request present
//  req_ready     out  1   sequencer can accept; 1 only in IDLE
//  req_op        in   2   0=MUL 1=MULXUU 2=MULXSU 3=MULXSS
//  req_src1      in   32  operand A (signed for MULXSU/MULXSS)
//  req_src2      in   32  operand B (signed for MULXSS only)
//  rsp_valid     out  1   result valid; held until rsp_ready
//  rsp_ready     in   1   consumer accepts result
//  rsp_result    out  32  product word
//  cell_src1     out  32  to cell E_src1
//  cell_src2     out  32  to cell E_src2
//  cell_en       out  1   to cell M_en
//  cell_p1       in   32  A[15:0]*B[15:0] from cell
//  cell_p2       in   32  A[15:0]*B[31:16] from cell
//  cell_p3       in   32  A[31:16]*B[15:0] from cell
// BEHAVIOUR
//  - Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_result=0, cell_en=0, cell_src1/2=0, all capture regs 0.
//  - FSM: IDLE -> PASS_LO -> (op==MUL ? DONE : PASS_HI) -> DONE -> IDLE.
//  - IDLE: on req_valid&&req_ready latch src1, src2, op into opA/opB/opR; go to PASS_LO; load cnt=CELL_LATENCY.
//  - PASS_LO: cell_src1=opA, cell_src2=opB, cell_en=1; cnt decrements each cycle.
//    When cnt==1, capture cell_p1/p2/p3 on the next edge into lo/m2/m3.
//  - PASS_HI: cell_src1={16'h0,opA[31:16]}, cell_src2={16'h0,opB[31:16]}, cell_en=1; reload cnt=CELL_LATENCY.
//    Capture cell_p1 into hh at cnt==1. cell_p2/p3 are ignored in this pass.
//  - cell_en=0 and cell_src*=0 in IDLE and DONE, so the cell does not toggle while idle.
//  - Assembly (all unsigned, 64-bit): full = lo + ((m2+m3)<<16) + (hh<<32); m2+m3 is kept 33 bits wide, no carry loss.
//  - MUL: rsp_result = full[31:0].
//  - MULXUU: rsp_result = full[63:32].
//  - MULXSU: rsp_result = full[63:32] - (opA[31] ? opB : 0), mod 2^32.
//  - MULXSS: rsp_result = full[63:32] - (opA[31] ? opB : 0) - (opB[31] ? opA : 0), mod 2^32.
//  - DONE: rsp_valid=1 and rsp_result registered on DONE entry.
//    rsp_result stays stable while rsp_valid && !rsp_ready.
//    On rsp_ready: go to IDLE, rsp_valid=0 on the next edge.
//  - Latency: accept at edge T.
//    MUL: rsp_valid rises at T+1+CELL_LATENCY+1.
//    High ops: rsp_valid rises at T+2*CELL_LATENCY+2.
//  - No new request is accepted until the response handshakes. Back-to-back requests: req_ready returns the cycle after rsp handshake.
//  - req_valid while busy is ignored; the requester holds it.
//  - Reset asserted mid-operation (any state): immediate return to reset values. The partial result is discarded, no rsp emitted.
//  - rsp_ready asserted with rsp_valid=0 has no effect.
// STRUCTURE
//  - Package mi_nios_mult_pkg: op encoding localparams (OP_MUL..OP_MULXSS), FSM state enum, MAX_CELL_LATENCY=4.
//  - Sub-module mi_nios_mult_combine: purely combinational.
//    Inputs lo, m2, m3, hh, opA, opB, op; output 32-bit word.
//    Contains the summation and signed correction, so the FSM and the arithmetic are verified separately.
//  - Top: FSM, latency counter, operand/capture registers, handshake logic.
// TESTING
//  - MUL 0x00010003 * 0x00020005 -> rsp_result=0x000B000F. rsp_valid exactly CELL_LATENCY+2 cycles after accept. Exactly one cell pass.
//  - MULXUU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE. Two cell passes; second pass cell_src1=0x0000FFFF.
//  - MULXSS 0xFFFFFFFF * 0x00000002 -> 0xFFFFFFFF. MULXSS 0x7FFFFFFF * 0x7FFFFFFF -> 0x3FFFFFFF.
//  - MULXSU 0x80000000 * 0x80000000 -> 0xC0000000.
//  - Hold rsp_ready=0 for 3 cycles in DONE: rsp_valid=1 and rsp_result stable, req_ready=0, cell_en=0. Handshake on the 4th cycle -> IDLE.
//  - Assert reset_n=0 during PASS_HI: next cycle rsp_valid=0, cell_en=0, req_ready=1.
//    A fresh MUL 3*5 after reset -> 0x0000000F. Repeat all cases with CELL_LATENCY=1 and 3.

Source files
------------

// File: rtl/mi_nios_mult_pkg.sv
// Shared definitions for the multiply sequencer: op encoding, FSM states,
// latency limits and a small op-classification helper.
package mi_nios_mult_pkg;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULXUU = 2'd1;
  localparam logic [1:0] OP_MULXSU = 2'd2;
  localparam logic [1:0] OP_MULXSS = 2'd3;

  localparam int MAX_CELL_LATENCY = 4;
  localparam int CNT_W            = $clog2(MAX_CELL_LATENCY + 1);

  // ST_ASSEMBLE waits for the trailing capture of the last pass, then
  // registers the assembled word on the way into ST_DONE.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PASS_LO  = 3'd1,
    ST_PASS_HI  = 3'd2,
    ST_ASSEMBLE = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // High-word ops need the second (A_hi * B_hi) pass through the cell.
  function automatic logic needs_hi_pass(input logic [1:0] op);
    return op != OP_MUL;
  endfunction

endpackage

// File: rtl/mi_nios_mult_combine.sv
// Combinational assembly of the cell partial products into the 32-bit
// result word, including the two's-complement correction for signed ops.
module mi_nios_mult_combine
  import mi_nios_mult_pkg::*;
(
  input  logic [31:0] lo,
  input  logic [31:0] m2,
  input  logic [31:0] m3,
  input  logic [31:0] hh,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [1:0]  op,
  output logic [31:0] word
);

  logic [32:0] mid;
  logic [63:0] full;
  logic [31:0] corr_a;
  logic [31:0] corr_b;

  // Unsigned 64-bit product from the partials, then subtract B (resp. A)
  // from the high word when the operand treated as signed is negative.
  always_comb begin
    mid    = {1'b0, m2} + {1'b0, m3};
    full   = {32'h0, lo} + {15'h0, mid, 16'h0} + {hh, 32'h0};
    corr_a = '0;
    corr_b = '0;
    if ((op == OP_MULXSU || op == OP_MULXSS) && op_a[31]) corr_a = op_b;
    if (op == OP_MULXSS && op_b[31]) corr_b = op_a;
    if (op == OP_MUL) word = full[31:0];
    else              word = full[63:32] - corr_a - corr_b;
  end

endmodule

// File: rtl/mi_nios_mult_sequencer.sv
// Sequences one or two passes through the pipelined 16x16 multiply cell,
// captures the partial products and returns the low or high product word.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | req_ready=1, cell quiet, waiting for a request
// ST_PASS_LO  | full operands on the cell for CELL_LATENCY cycles
// ST_PASS_HI  | upper halves on the cell for CELL_LATENCY cycles
// ST_ASSEMBLE | cell quiet; last pass product lands, then result registers
// ST_DONE     | rsp_valid=1, result held until rsp_ready
//
// The cell is pipelined: products of operands issued in a pass appear one
// edge after that pass ends, so captures trail the issue by one edge and
// the high pass is issued while the low pass is still draining.
module mi_nios_mult_sequencer
  import mi_nios_mult_pkg::*;
#(
  parameter int CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CELL_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [1:0]       op_r;
  logic             cap_lo;
  logic             cap_hh;
  logic [31:0]      lo;
  logic [31:0]      m2;
  logic [31:0]      m3;
  logic [31:0]      hh;
  logic [31:0]      assembled;

  mi_nios_mult_combine u_combine (
    .lo   (lo),
    .m2   (m2),
    .m3   (m3),
    .hh   (hh),
    .op_a (op_a),
    .op_b (op_b),
    .op   (op_r),
    .word (assembled)
  );

  // Sequencer FSM with pass counter, capture registers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_r       <= OP_MUL;
      cap_lo     <= 1'b0;
      cap_hh     <= 1'b0;
      lo         <= '0;
      m2         <= '0;
      m3         <= '0;
      hh         <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      cell_en    <= 1'b0;
      cell_src1  <= '0;
      cell_src2  <= '0;
    end else begin
      cap_lo <= 1'b0;
      cap_hh <= 1'b0;
      if (cap_lo) begin
        lo <= cell_p1;
        m2 <= cell_p2;
        m3 <= cell_p3;
      end
      if (cap_hh) hh <= cell_p1;

      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_a      <= req_src1;
            op_b      <= req_src2;
            op_r      <= req_op;
            cnt       <= CNT_LOAD;
            req_ready <= 1'b0;
            cell_en   <= 1'b1;
            cell_src1 <= req_src1;
            cell_src2 <= req_src2;
            state     <= ST_PASS_LO;
          end
        end

        ST_PASS_LO: begin
          if (cnt == CNT_ONE) begin
            cap_lo <= 1'b1;
            cnt    <= CNT_LOAD;
            if (needs_hi_pass(op_r)) begin
              cell_src1 <= {16'h0, op_a[31:16]};
              cell_src2 <= {16'h0, op_b[31:16]};
              state     <= ST_PASS_HI;
            end else begin
              cell_en   <= 1'b0;
              cell_src1 <= '0;
              cell_src2 <= '0;
              state     <= ST_ASSEMBLE;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        ST_PASS_HI: begin
          if (cnt == CNT_ONE) begin
            cap_hh    <= 1'b1;
            cell_en   <= 1'b0;
            cell_src1 <= '0;
            cell_src2 <= '0;
            state     <= ST_ASSEMBLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        ST_ASSEMBLE: begin
          if (!cap_lo && !cap_hh) begin
            rsp_result <= assembled;
            rsp_valid  <= 1'b1;
            state      <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          cell_en   <= 1'b0;
          cell_src1 <= '0;
          cell_src2 <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mi_nios_mult_sequencer.sv
// Bench for mi_nios_mult_sequencer: two instances (CELL_LATENCY 1 and 3),
// each with its own pipelined cell model; sel picks the one under test.
module tb_mi_nios_mult_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        rsp_ready;
  logic        sel;

  logic [1:0]  req_ready_v;
  logic [1:0]  rsp_valid_v;
  logic [1:0]  cell_en_v;
  logic [1:0]  req_valid_v;
  logic [1:0]  rsp_ready_v;
  logic [31:0] rsp_result_v [2];
  logic [31:0] cell_src1_v  [2];
  logic [31:0] cell_src2_v  [2];
  logic [31:0] p1_v         [2];
  logic [31:0] p2_v         [2];
  logic [31:0] p3_v         [2];

  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam int L = (k == 0) ? 1 : 3;
    logic [31:0] s1 [L];
    logic [31:0] s2 [L];
    logic [31:0] s3 [L];

    assign req_valid_v[k] = req_valid & (int'(sel) == k);
    assign rsp_ready_v[k] = rsp_ready & (int'(sel) == k);

    mi_nios_mult_sequencer #(.CELL_LATENCY(L)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid_v[k]),
      .req_ready  (req_ready_v[k]),
      .req_op     (req_op),
      .req_src1   (req_src1),
      .req_src2   (req_src2),
      .rsp_valid  (rsp_valid_v[k]),
      .rsp_ready  (rsp_ready_v[k]),
      .rsp_result (rsp_result_v[k]),
      .cell_src1  (cell_src1_v[k]),
      .cell_src2  (cell_src2_v[k]),
      .cell_en    (cell_en_v[k]),
      .cell_p1    (p1_v[k]),
      .cell_p2    (p2_v[k]),
      .cell_p3    (p3_v[k])
    );

    // Cell: L-stage pipeline advancing only while enabled.
    always @(posedge clk) begin
      if (cell_en_v[k]) begin
        s1[0] <= 32'(cell_src1_v[k][15:0])  * 32'(cell_src2_v[k][15:0]);
        s2[0] <= 32'(cell_src1_v[k][15:0])  * 32'(cell_src2_v[k][31:16]);
        s3[0] <= 32'(cell_src1_v[k][31:16]) * 32'(cell_src2_v[k][15:0]);
        for (int i = 1; i < L; i++) begin
          s1[i] <= s1[i-1];
          s2[i] <= s2[i-1];
          s3[i] <= s3[i-1];
        end
      end
    end
    assign p1_v[k] = s1[L-1];
    assign p2_v[k] = s2[L-1];
    assign p3_v[k] = s3[L-1];
  end

  logic        req_ready_s, rsp_valid_s, cell_en_s;
  logic [31:0] rsp_result_s, cell_src1_s, cell_src2_s;
  assign req_ready_s  = req_ready_v[sel];
  assign rsp_valid_s  = rsp_valid_v[sel];
  assign cell_en_s    = cell_en_v[sel];
  assign rsp_result_s = rsp_result_v[sel];
  assign cell_src1_s  = cell_src1_v[sel];
  assign cell_src2_s  = cell_src2_v[sel];

  int          en_total = 0;
  logic [31:0] last_src1 = '0;
  always @(posedge clk) begin
    if (cell_en_s) begin
      en_total  <= en_total + 1;
      last_src1 <= cell_src1_s;
    end
  end

  int total = 0;
  int bad   = 0;
  int lat;
  int en0;

  // Reference: exact 64-bit product with operands extended per op signedness.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = (op == 2'd2 || op == 2'd3) ? {{32{a[31]}}, a} : {32'h0, a};
    xb = (op == 2'd3) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = xa * xb;
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    total++;
    if (req_ready_s !== 1'b1) begin
      bad++;
      $display("FAIL send_ready L=%0d got=%b want=1", lat, req_ready_s);
    end
    en0 = en_total;
    @(negedge clk);
    total++;
    if (req_ready_s !== 1'b0) begin
      bad++;
      $display("FAIL busy_ready L=%0d got=%b want=0", lat, req_ready_s);
    end
  endtask

  task automatic expect_rsp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int hold);
    logic [31:0] exp_word, held;
    int c, exp_lat, exp_pass;
    exp_word = ref_mul(op, a, b);
    exp_lat  = (op == 2'd0) ? lat + 2 : 2 * lat + 2;
    exp_pass = (op == 2'd0) ? lat : 2 * lat;
    c = 0;
    while (rsp_valid_s !== 1'b1 && c < 40) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (c != exp_lat) begin
      bad++;
      $display("FAIL latency L=%0d op=%0d got=%0d want=%0d", lat, op, c, exp_lat);
    end
    if (rsp_valid_s !== 1'b1) return;
    total++;
    if (rsp_result_s !== exp_word) begin
      bad++;
      $display("FAIL result L=%0d op=%0d a=%h b=%h got=%h want=%h",
               lat, op, a, b, rsp_result_s, exp_word);
    end
    total++;
    if (en_total - en0 != exp_pass) begin
      bad++;
      $display("FAIL cell_en_cycles L=%0d op=%0d got=%0d want=%0d",
               lat, op, en_total - en0, exp_pass);
    end
    if (op != 2'd0) begin
      total++;
      if (last_src1 !== {16'h0, a[31:16]}) begin
        bad++;
        $display("FAIL hi_pass_src1 L=%0d got=%h want=%h", lat, last_src1, {16'h0, a[31:16]});
      end
    end
    held = rsp_result_s;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      total++;
      if (rsp_valid_s !== 1'b1 || rsp_result_s !== held || req_ready_s !== 1'b0 ||
          cell_en_s !== 1'b0) begin
        bad++;
        $display("FAIL done_hold L=%0d v=%b r=%h rdy=%b en=%b want v=1 r=%h rdy=0 en=0",
                 lat, rsp_valid_s, rsp_result_s, req_ready_s, cell_en_s, held);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid_s !== 1'b0 || req_ready_s !== 1'b1) begin
      bad++;
      $display("FAIL handshake L=%0d rsp_valid=%b req_ready=%b want 0/1",
               lat, rsp_valid_s, req_ready_s);
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    send(op, a, b);
    req_valid = 1'b0;
    expect_rsp(op, a, b, hold);
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_op    = 2'd0;
    req_src1  = '0;
    req_src2  = '0;
    repeat (2) @(negedge clk);
    total++;
    if (req_ready_s !== 1'b1 || rsp_valid_s !== 1'b0 || rsp_result_s !== 32'h0 ||
        cell_en_s !== 1'b0 || cell_src1_s !== 32'h0 || cell_src2_s !== 32'h0) begin
      bad++;
      $display("FAIL reset_values L=%0d rdy=%b v=%b r=%h en=%b s1=%h s2=%h want 1/0/0/0/0/0",
               lat, req_ready_s, rsp_valid_s, rsp_result_s, cell_en_s, cell_src1_s, cell_src2_s);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_op(2'd0, 32'h0001_0003, 32'h0002_0005, 0);
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(2'd3, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    do_op(2'd3, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
    do_op(2'd2, 32'h8000_0000, 32'h8000_0000, 0);
  endtask

  task automatic test_hold();
    do_op(2'd2, 32'hDEAD_BEEF, 32'h1234_5678, 2);
  endtask

  task automatic test_idle_rsp_ready();
    rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (rsp_valid_s !== 1'b0 || req_ready_s !== 1'b1) begin
        bad++;
        $display("FAIL idle_rsp_ready L=%0d v=%b rdy=%b want 0/1", lat, rsp_valid_s, req_ready_s);
      end
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    send(2'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    req_valid = 1'b0;
    repeat (lat) @(negedge clk);
    total++;
    if (cell_en_s !== 1'b1 || cell_src1_s !== 32'h0000_1234) begin
      bad++;
      $display("FAIL pass_hi_drive L=%0d en=%b s1=%h want 1/00001234", lat, cell_en_s, cell_src1_s);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (rsp_valid_s !== 1'b0 || cell_en_s !== 1'b0 || req_ready_s !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid L=%0d v=%b en=%b rdy=%b want 0/0/1",
               lat, rsp_valid_s, cell_en_s, req_ready_s);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_op(2'd0, 32'd3, 32'd5, 0);
  endtask

  task automatic test_back_to_back();
    send(2'd1, 32'hCAFE_F00D, 32'h0BAD_1DEA);
    req_op   = 2'd3;
    req_src1 = 32'h8765_4321;
    req_src2 = 32'hF0F0_1234;
    expect_rsp(2'd1, 32'hCAFE_F00D, 32'h0BAD_1DEA, 0);
    send(2'd3, 32'h8765_4321, 32'hF0F0_1234);
    req_valid = 1'b0;
    expect_rsp(2'd3, 32'h8765_4321, 32'hF0F0_1234, 1);
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int n = 0; n < 20; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 3))
        0: a = a | 32'h8000_0000;
        1: b = b | 32'h8000_FFFF;
        2: begin a = a & 32'h0000_FFFF; b = b | 32'hFFFF_0000; end
        default: ;
      endcase
      do_op(op, a, b, $urandom_range(0, 2));
    end
  endtask

  task automatic run_all();
    test_reset();
    test_directed();
    test_hold();
    test_idle_rsp_ready();
    test_reset_mid();
    test_back_to_back();
    test_random();
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_op    = 2'd0;
    req_src1  = '0;
    req_src2  = '0;
    sel       = 1'b0;
    lat       = 1;
    run_all();
    @(negedge clk);
    sel = 1'b1;
    lat = 3;
    run_all();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
